// File: rtl/mux_arb_2to1.sv
// rtl/mux_arb_2to1.sv - two-requester round-robin arbiter driving a shared 2:1 operand mux into one output register (optional grant lock: ARB_LOCK_EN)
module mux_arb_2to1 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    input  logic         req0_lock,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    input  logic         req1_lock,
    output logic         req1_ready,
    output logic         mux_sel,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_src_q, out_src_d;
    logic           last_q, last_d;

    logic           load_en;
    logic           gnt_any;
    logic           gnt_idx;
    logic           xfer;
    logic [N-1:0]   mux_word;

`ifdef ARB_LOCK_EN
    logic           locked_q, locked_d;
    logic           owner_q, owner_d;
    logic           owner_valid;

    assign owner_valid = owner_q ? req1_valid : req0_valid;
`else
    logic           unused_lock;

    assign unused_lock = req0_lock | req1_lock;
`endif

    // Grant: lone requester wins, contention goes to the one that did not win last
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_idx = last_q;
        if (req0_valid && req1_valid) begin
            gnt_idx = ~last_q;
        end else if (req1_valid) begin
            gnt_idx = 1'b1;
        end else if (req0_valid) begin
            gnt_idx = 1'b0;
        end
`ifdef ARB_LOCK_EN
        if (locked_q && owner_valid) begin
            gnt_idx = owner_q;
        end
`endif
    end

    // Ready is gated by rstb so nothing is accepted while reset is held
    assign load_en    = (state_q == EMPTY) || out_ready;
    assign mux_sel    = gnt_idx;
    assign mux_word   = mux_sel ? req1_data : req0_data;
    assign req0_ready = rstb && load_en && gnt_any && (gnt_idx == 1'b0);
    assign req1_ready = rstb && load_en && gnt_any && (gnt_idx == 1'b1);
    assign xfer       = req0_ready | req1_ready;

    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;

    // Output slot FSM and capture of the granted word
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_d     = last_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (out_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            out_data_d = mux_word;
            out_src_d  = gnt_idx;
            last_d     = gnt_idx;
        end
    end

`ifdef ARB_LOCK_EN
    // Lock follows the lock bit of each transfer and drops once the owner goes idle
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (xfer) begin
            locked_d = gnt_idx ? req1_lock : req0_lock;
            owner_d  = gnt_idx;
        end else if (locked_q && !owner_valid) begin
            locked_d = 1'b0;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`endif

    // State and output registers; last resets to 1 so req0 wins first contention
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_mux_arb_2to1.sv
// tb/tb_mux_arb_2to1.sv - directed self-checking bench for mux_arb_2to1
module tb_mux_arb_2to1;

    localparam int N = 16;

    logic         clk;
    logic         rstb;
    logic         req0_valid;
    logic [N-1:0] req0_data;
    logic         req0_lock;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_data;
    logic         req1_lock;
    logic         req1_ready;
    logic         mux_sel;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    mux_arb_2to1 #(.N(N)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_lock  (req0_lock),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_lock  (req1_lock),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [4:0]   exp_src_tbl;
        int           n0;
        logic         e_src;
        logic [N-1:0] e_data;

`ifdef ARB_LOCK_EN
        exp_src_tbl = 5'b10000;
`else
        exp_src_tbl = 5'b01010;
`endif

        rstb       = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 16'h1111;
        req0_lock  = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 16'h2222;
        req1_lock  = 1'b0;
        out_ready  = 1'b1;

        // Reset state, including readys held low during reset
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);

        // Release with both valid: req0 wins first, then strict alternation
        @(negedge clk);
        rstb = 1'b1;
        #1;
        check("rel_req0_ready", 32'(req0_ready), 32'd1);
        check("rel_req1_ready", 32'(req1_ready), 32'd0);
        check("rel_mux_sel", 32'(mux_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_src", 32'(out_src), 32'(i % 2));
            check("rr_out_data", 32'(out_data), (i % 2 == 1) ? 32'h2222 : 32'h1111);
        end

        // Only req1 valid
        @(negedge clk);
        req0_valid = 1'b0;
        req1_data  = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("solo_mux_sel", 32'(mux_sel), 32'd1);
            check("solo_req1_ready", 32'(req1_ready), 32'd1);
            check("solo_req0_ready", 32'(req0_ready), 32'd0);
            @(posedge clk);
            #1;
            check("solo_out_data", 32'(out_data), 32'hBEEF);
            check("solo_out_src", 32'(out_src), 32'd1);
            @(negedge clk);
        end

        // Output stall for 3 cycles with both valid
        req0_valid = 1'b1;
        req0_data  = 16'h1111;
        req1_data  = 16'h2222;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_req0_ready", 32'(req0_ready), 32'd0);
            check("stall_req1_ready", 32'(req1_ready), 32'd0);
            check("stall_mux_sel", 32'(mux_sel), 32'd0);
            @(posedge clk);
            #1;
            check("stall_out_data", 32'(out_data), 32'hBEEF);
            check("stall_out_src", 32'(out_src), 32'd1);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        check("unstall_out_data", 32'(out_data), 32'h1111);
        check("unstall_out_valid", 32'(out_valid), 32'd1);
        check("unstall_out_src", 32'(out_src), 32'd0);

        // Reset pulse while full; afterwards req0 must win again
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'h0);
        check("mid_rst_out_src", 32'(out_src), 32'd0);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        check("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_out_src", 32'(out_src), 32'd0);
        check("post_rst_out_data", 32'(out_data), 32'h1111);

        // Put last at req1 so req0 wins the next contention
        @(negedge clk);
        req0_valid = 1'b0;
        req1_data  = 16'h5555;
        @(posedge clk);
        #1;
        check("prep_out_src", 32'(out_src), 32'd1);

        // Lock sequence: req0 sends 3 locked words then 1 unlocked, req1 always valid
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req0_data  = 16'hA000 + 16'(n0);
            req0_lock  = (n0 < 3);
            e_src      = exp_src_tbl[i];
            e_data     = e_src ? 16'h5555 : (16'hA000 + 16'(n0));
            @(posedge clk);
            #1;
            check("lock_out_src", 32'(out_src), 32'(e_src));
            check("lock_out_data", 32'(out_data), 32'(e_data));
            if (!e_src) n0++;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
